// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA raster timing for 1440x900@60 (geometry is parameterised).
//
// Scans h_cnt/v_cnt over the full raster, publishing them as draw_x/draw_y to the
// drawing controller together with undelayed pix_active, frame_start and frame_done.
// hsync, vsync and blanked RGB are delayed by PIPE_DEPTH cycles so they line up with
// the colour the controller returns for each coordinate.
//
// Ports:
//   clk, rst            pixel clock; synchronous active-high reset
//   r_in, g_in, b_in    4-bit colour from the drawing controller
//   draw_x, draw_y      current raster position (includes blanking)
//   pix_active          current position is inside the visible area
//   frame_start         1-cycle pulse at (0,0)
//   frame_done          1-cycle pulse at (H_TOTAL-1, V_ACTIVE-1)
//   hsync, vsync        sync outputs, PIPE_DEPTH cycles after their coordinate
//   r_out, g_out, b_out colour to the DAC, forced to 0 during blanking
//
// Optional build macro TEST_PATTERN_EN: ignore r/g/b_in and drive eight vertical
// colour bars derived from the delayed x coordinate.

module vga_timing_gen #(
  parameter int H_ACTIVE   = 1440,
  parameter int H_FP       = 80,
  parameter int H_SYNC     = 152,
  parameter int H_BP       = 232,
  parameter int V_ACTIVE   = 900,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 25,
  parameter int H_POL      = 0,
  parameter int V_POL      = 1,
  parameter int PIPE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  output logic [10:0] draw_x,
  output logic [9:0]  draw_y,
  output logic        pix_active,
  output logic        frame_start,
  output logic        frame_done,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  r_out,
  output logic [3:0]  g_out,
  output logic [3:0]  b_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT_END   = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_LAST   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic H_ON = (H_POL != 0);
  localparam logic V_ON = (V_POL != 0);

  // Tap feeding the colour register: the stage one cycle before the output stage.
  localparam int LEAD = (PIPE_DEPTH > 1) ? PIPE_DEPTH - 2 : 0;

  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCS, V_BACK} v_state_t;

  v_state_t v_state, v_state_nxt;

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        running;
  logic        h_wrap;
  logic        hs_raw;
  logic        vs_raw;

  logic [PIPE_DEPTH-1:0] hs_q;
  logic [PIPE_DEPTH-1:0] vs_q;
  logic [PIPE_DEPTH-1:0] act_q;

  // running holds the counters at 0,0 for the first cycle after reset so that
  // coordinate (0,0) is issued with pix_active and frame_start asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      v_state <= V_ACT;
    end else begin
      running <= 1'b1;
      v_state <= v_state_nxt;
      if (running) begin
        if (h_wrap) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 11'd1;
        end
      end
    end
  end

  assign h_wrap = running && (h_cnt == H_LAST);

  always_comb begin
    v_state_nxt = v_state;
    if (h_wrap) begin
      unique case (v_state)
        V_ACT:   if (v_cnt == V_ACT_LAST)  v_state_nxt = V_FRONT;
        V_FRONT: if (v_cnt == V_FP_LAST)   v_state_nxt = V_SYNCS;
        V_SYNCS: if (v_cnt == V_SYNC_LAST) v_state_nxt = V_BACK;
        V_BACK:  if (v_cnt == V_LAST)      v_state_nxt = V_ACT;
        default: v_state_nxt = V_ACT;
      endcase
    end
  end

  assign draw_x      = h_cnt;
  assign draw_y      = v_cnt;
  assign pix_active  = running && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign frame_start = running && (h_cnt == '0) && (v_cnt == '0);
  assign frame_done  = running && (h_cnt == H_LAST) && (v_cnt == V_ACT_LAST);

  // Sync pipeline carries "in sync" flags; polarity is applied at the output.
  assign hs_raw = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign vs_raw = (v_state == V_SYNCS);

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q  <= '0;
      vs_q  <= '0;
      act_q <= '0;
    end else begin
      hs_q[0]  <= hs_raw;
      vs_q[0]  <= vs_raw;
      act_q[0] <= pix_active;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        hs_q[i]  <= hs_q[i-1];
        vs_q[i]  <= vs_q[i-1];
        act_q[i] <= act_q[i-1];
      end
    end
  end

  assign hsync = hs_q[PIPE_DEPTH-1] ? H_ON : ~H_ON;
  assign vsync = vs_q[PIPE_DEPTH-1] ? V_ON : ~V_ON;

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [PIPE_DEPTH-1:0][10:0] x_q;
  logic [2:0]  bar_idx;
  logic [11:0] bar_rgb;
  logic        unused_rgb_in;

  assign unused_rgb_in = ^{r_in, g_in, b_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
    end else begin
      x_q[0] <= h_cnt;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        x_q[i] <= x_q[i-1];
      end
    end
  end

  // Bar index 0..7 maps to FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000:
  // red off for bars 2,3,6,7; green off for 4..7; blue off for odd bars.
  always_comb begin
    bar_idx = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (x_q[PIPE_DEPTH-1] >= 11'(i * BAR_W)) bar_idx = 3'(i);
    end
    bar_rgb = {{4{~bar_idx[1]}}, {4{~bar_idx[2]}}, {4{~bar_idx[0]}}};
  end

  assign {r_out, g_out, b_out} = act_q[PIPE_DEPTH-1] ? bar_rgb : '0;
`else
  logic        act_lead;
  logic [11:0] rgb_q;

  // Colour is captured on the edge that ends cycle t+PIPE_DEPTH-1, so the
  // register is qualified by the blanking flag one stage ahead of the output.
  assign act_lead = (PIPE_DEPTH > 1) ? act_q[LEAD] : pix_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= act_lead ? {r_in, g_in, b_in} : '0;
    end
  end

  assign {r_out, g_out, b_out} = rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen on a reduced 16x8 raster (24x13 total) so that
// several whole frames run in a few thousand cycles.

module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int PD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int MAX_CYC = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  r_in = '0, g_in = '0, b_in = '0;
  logic [10:0] draw_x;
  logic [9:0]  draw_y;
  logic        pix_active, frame_start, frame_done, hsync, vsync;
  logic [3:0]  r_out, g_out, b_out;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(0), .V_POL(1), .PIPE_DEPTH(PD)
  ) dut (
    .clk(clk), .rst(rst),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .draw_x(draw_x), .draw_y(draw_y),
    .pix_active(pix_active), .frame_start(frame_start), .frame_done(frame_done),
    .hsync(hsync), .vsync(vsync),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic [10:0] x;
  } exp_t;

  exp_t q[$];

  int passed = 0;
  int total  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [11:0] exp_colour(input logic [10:0] x, input logic [11:0] rgb_held);
`ifdef TEST_PATTERN_EN
    logic [11:0] bars [8];
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    return bars[int'(x) / (HA / 8)];
`else
    return rgb_held;
`endif
  endfunction

  initial begin
    int   mx = 0, my = 0;
    bit   mrun = 1'b0;
    bit   mid_done = 1'b0;
    int   fs_count = 0, fs_cyc1 = 0;
    int   hs_seen = 0, vs_seen = 0;
    int   cyc;
    logic m_act, m_fs, m_fd;
    logic [11:0] rgb_prev, rgb_exp;
    exp_t e, cur;

    for (cyc = 0; cyc < MAX_CYC && fs_count < 5; cyc++) begin
      @(negedge clk);
      rgb_prev = {r_in, g_in, b_in};

      // Model of the raster after the edge that just passed.
      if (rst) begin
        mrun = 1'b0; mx = 0; my = 0;
      end else if (!mrun) begin
        mrun = 1'b1;
      end else if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end

      m_act = mrun && (mx < HA) && (my < VA);
      m_fs  = mrun && (mx == 0) && (my == 0);
      m_fd  = mrun && (mx == HT - 1) && (my == VA - 1);

      check_eq("draw_x", 32'(draw_x), 32'(mx));
      check_eq("draw_y", 32'(draw_y), 32'(my));
      check_eq("pix_active", 32'(pix_active), 32'(m_act));
      check_eq("frame_start", 32'(frame_start), 32'(m_fs));
      check_eq("frame_done", 32'(frame_done), 32'(m_fd));

      // Scoreboard for the delayed outputs.
      if (rst) begin
        q.delete();
        repeat (PD - 1) q.push_back('0);
        e = '0;
        rgb_exp = '0;
      end else begin
        e = q.pop_front();
        rgb_exp = e.act ? exp_colour(e.x, rgb_prev) : 12'h000;
      end
      check_eq("hsync", 32'(hsync), 32'(e.hs ? 1'b0 : 1'b1));
      check_eq("vsync", 32'(vsync), 32'(e.vs ? 1'b1 : 1'b0));
      check_eq("rgb_out", 32'({r_out, g_out, b_out}), 32'(rgb_exp));

      cur.hs  = mrun && (mx >= HA + HF) && (mx < HA + HF + HS);
      cur.vs  = mrun && (my >= VA + VF) && (my < VA + VF + VS);
      cur.act = m_act;
      cur.x   = 11'(mx);
      q.push_back(cur);

      if (m_fs) begin
        fs_count++;
        if (fs_count == 1) fs_cyc1 = cyc;
        if (fs_count == 2) check_eq("frame_period", 32'(cyc - fs_cyc1), 32'(HT * VT));
      end
      if (fs_count == 1) begin
        if (hsync == 1'b0) hs_seen++;
        if (vsync == 1'b1) vs_seen++;
      end

      // Drive inputs for the next edge.
      if (fs_count == 3 && mx == 10 && my == 5 && !mid_done) begin
        rst = 1'b1;
        mid_done = 1'b1;
      end else begin
        rst = (cyc < 2);
      end
      if (fs_count == 2) {r_in, g_in, b_in} = 12'hFFF;
      else               {r_in, g_in, b_in} = 12'($urandom);
    end

    check_eq("frames_seen", 32'(fs_count), 32'd5);
    check_eq("mid_reset_applied", 32'(mid_done), 32'd1);
    check_eq("hsync_cycles_per_frame", 32'(hs_seen), 32'(HS * VT));
    check_eq("vsync_cycles_per_frame", 32'(vs_seen), 32'(VS * HT));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
